// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared run-length token layout for the COUNT encoder and decoder
package rle_pkg;

  localparam int DW      = 8;
  localparam int CW      = 3;
  localparam int RUN_MAX = (1 << CW) - 1;
  localparam int TW      = DW + CW;

  // Token bit layout is {DATA, COUNT}, identical on the encoder side.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] count;
  } token_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } exp_state_t;

endpackage

// File: rtl/rle_token_fifo.sv
// rtl/rle_token_fifo.sv - synchronous token FIFO with registered occupancy
module rle_token_fifo
  import rle_pkg::*;
#(
  parameter int W     = TW,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rle_decode.sv
// rtl/rle_decode.sv - run-length decoder: token FIFO feeding a one-byte-per-cycle expander
module rle_decode
  import rle_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_in_data,
  input  logic [CW-1:0] i_in_count,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_err
);

  exp_state_t    r_state;
  exp_state_t    w_state_nxt;
  logic [CW-1:0] r_rem;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;

  token_t        w_in_tok;
  token_t        w_head;
  logic [TW-1:0] w_fifo_rdata;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_load;
  logic          w_err;
  logic          w_head_zero;
  logic          w_hs;
  logic          w_last;

  assign w_in_tok = '{data: i_in_data, count: i_in_count};
  assign w_head   = w_fifo_rdata;

  rle_token_fifo #(
    .W     (TW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_in_valid),
    .i_wdata (w_in_tok),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_zero = !w_empty && (w_head.count == '0);
  assign w_hs        = r_out_valid && i_out_ready;
  assign w_last      = w_hs && (r_rem == CW'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Zero-count tokens are dropped the moment they reach the head, in either state.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_err       = w_head_zero;
    case (r_state)
      ST_IDLE: begin
        if (w_head_zero) begin
          w_pop = 1'b1;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_head_zero) begin
          w_pop = 1'b1;
          if (w_last) w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_rem       <= w_head.count;
      r_out_data  <= w_head.data;
      r_out_valid <= 1'b1;
    end else if (w_hs) begin
      r_rem <= r_rem - 1'b1;
      if (r_rem == CW'(1)) r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = !w_full;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_err       = w_err;

endmodule

// File: tb/tb_rle_decode.sv
// tb/tb_rle_decode.sv - directed self-checking bench for rle_decode
module tb_rle_decode;
  import rle_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_count;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err;

  rle_decode #(.FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (in_data),
    .i_in_count  (in_count),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  int         qc[$];
  int         cyc = 0;
  int         err_cnt = 0;
  int         stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // Output monitor: inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (err) err_cnt++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        q.push_back(out_data);
        qc.push_back(cyc);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push(input logic [7:0] d, input logic [2:0] c);
    int t = 0;
    in_data  = d;
    in_count = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: in_ready stayed %0b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int t = 0;
    while (quiet < 4 && t < 400) begin
      @(negedge clk); #1;
      t++;
      if (out_valid || !in_ready) quiet = 0;
      else quiet++;
    end
    if (t >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_idle_timeout: out_valid=%0b in_ready=%0b, want 0/1", name, out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_after: got %0b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [8];
    int c_push;
    exp_b = '{8'd99, 8'd99, 8'd97, 8'd97, 8'd97, 8'd98, 8'd100, 8'd100};
    q.delete(); qc.delete(); err_cnt = 0;
    out_ready = 1'b1;
    push(8'd99, 3'd2);
    c_push = cyc;
    push(8'd97, 3'd3);
    push(8'd98, 3'd1);
    push(8'd100, 3'd2);
    wait_idle("basic");
    n_cmp++; if (q.size() != 8) begin n_bad++; $display("FAIL basic_len: got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      n_cmp++;
      if (q[i] !== exp_b[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %0d want %0d", i, q[i], exp_b[i]); end
    end
    if (q.size() > 0) begin
      n_cmp++;
      if (qc[0] != c_push + 2) begin n_bad++; $display("FAIL basic_latency: first byte at cycle %0d want %0d", qc[0], c_push + 2); end
      n_cmp++;
      if (qc[qc.size()-1] - qc[0] != q.size() - 1) begin
        n_bad++; $display("FAIL basic_gapfree: span %0d want %0d", qc[qc.size()-1] - qc[0], q.size() - 1);
      end
    end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL basic_err: got %0d pulses want 0", err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [6];
    int n55 = 0;
    exp_b = '{8'd55, 8'd55, 8'd55, 8'd55, 8'd66, 8'd77};
    q.delete(); qc.delete(); stall_bad = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
      begin
        push(8'd55, 3'd4);
        push(8'd66, 3'd1);
        push(8'd77, 3'd1);
        @(negedge clk); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); end
      end
    join
    out_ready = 1'b1;
    wait_idle("bp");
    for (int i = 0; i < q.size(); i++) if (q[i] == 8'd55) n55++;
    n_cmp++; if (n55 != 4) begin n_bad++; $display("FAIL bp_count55: got %0d want 4", n55); end
    n_cmp++; if (q.size() != 6) begin n_bad++; $display("FAIL bp_len: got %0d want 6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      n_cmp++;
      if (q[i] !== exp_b[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %0d want %0d", i, q[i], exp_b[i]); end
    end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_bad); end
  endtask

  task automatic test_illegal_count();
    q.delete(); qc.delete(); err_cnt = 0;
    out_ready = 1'b1;
    push(8'd12, 3'd0);
    push(8'd13, 3'd1);
    wait_idle("illegal");
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL illegal_err: got %0d pulses want 1", err_cnt); end
    n_cmp++; if (q.size() != 1) begin n_bad++; $display("FAIL illegal_len: got %0d want 1", q.size()); end
    if (q.size() > 0) begin
      n_cmp++; if (q[0] !== 8'd13) begin n_bad++; $display("FAIL illegal_byte: got %0d want 13", q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    q.delete(); qc.delete();
    out_ready = 1'b1;
    push(8'hFF, 3'd7);
    push(8'h00, 3'd7);
    wait_idle("b2b");
    n_cmp++; if (q.size() != 14) begin n_bad++; $display("FAIL b2b_len: got %0d want 14", q.size()); end
    for (int i = 0; i < 14 && i < q.size(); i++) begin
      n_cmp++;
      if (q[i] !== ((i < 7) ? 8'hFF : 8'h00)) begin
        n_bad++; $display("FAIL b2b_byte%0d: got %0h want %0h", i, q[i], (i < 7) ? 8'hFF : 8'h00);
      end
    end
    if (q.size() > 0) begin
      n_cmp++;
      if (qc[qc.size()-1] - qc[0] != q.size() - 1) begin
        n_bad++; $display("FAIL b2b_gapfree: span %0d want %0d", qc[qc.size()-1] - qc[0], q.size() - 1);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int t = 0;
    q.delete(); qc.delete();
    out_ready = 1'b1;
    push(8'd7, 3'd5);
    while (q.size() < 2 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    n_cmp++; if (q.size() != 2) begin n_bad++; $display("FAIL rstmid_prefix: got %0d bytes want 2", q.size()); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid_async: got %0b want 0", out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (q.size() != 2) begin n_bad++; $display("FAIL rstmid_no_more: got %0d bytes want 2", q.size()); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_round_trip();
    logic [7:0] raw[$];
    logic [7:0] v;
    int i;
    int n;
    int bad = 0;
    q.delete(); qc.delete(); err_cnt = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 48; k++) raw.push_back(8'($urandom_range(0, 2) * 50));
    i = 0;
    while (i < raw.size()) begin
      v = raw[i];
      n = 1;
      while (i + n < raw.size() && raw[i+n] == v && n < RUN_MAX) n++;
      push(v, 3'(n));
      i += n;
    end
    wait_idle("rt");
    n_cmp++; if (q.size() != raw.size()) begin n_bad++; $display("FAIL rt_len: got %0d want %0d", q.size(), raw.size()); end
    for (int k = 0; k < raw.size() && k < q.size(); k++) if (q[k] !== raw[k]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rt_stream: %0d bytes differ want 0", bad); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL rt_err: got %0d pulses want 0", err_cnt); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_count  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal_count();
    test_back_to_back();
    test_reset_mid_run();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
